// File: rtl/f5_sweep_ctrl.sv
// Clocked sequencer that sweeps the f5 datapath through every minterm, captures
// both implementations' outputs and reports the truth table, mismatch mask and pass.
module f5_sweep_ctrl #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1,
  localparam int M     = 2 ** N_IN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic [N_IN-1:0] x,
  input  logic            sa,
  input  logic            sb,
  output logic            busy,
  output logic            done,
  output logic [M-1:0]    table_out,
  output logic [M-1:0]    mismatch,
  output logic            pass
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DRIVE  = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  logic [1:0]      state;
  logic [N_IN-1:0] idx;
  logic [CW-1:0]   cnt;

  // The datapath sees the minterm only while a sweep is in flight; otherwise it rests at 0.
  assign busy = (state == S_DRIVE) || (state == S_SAMPLE);
  assign x    = busy ? idx : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      cnt       <= '0;
      table_out <= '0;
      mismatch  <= '0;
      pass      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            table_out <= '0;
            mismatch  <= '0;
            pass      <= 1'b0;
            idx       <= '0;
            cnt       <= '0;
            state     <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          if (cnt == CW'(SETTLE - 1)) begin
            state <= S_SAMPLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_SAMPLE: begin
          table_out[idx] <= sa;
          mismatch[idx]  <= sa ^ sb;
          cnt            <= '0;
          if (idx == N_IN'(M - 1)) begin
            state <= S_DONE;
          end else begin
            idx   <= idx + N_IN'(1);
            state <= S_DRIVE;
          end
        end
        S_DONE: begin
          // mismatch already holds the last minterm's capture here, so pass is final.
          done  <= 1'b1;
          pass  <= ~|mismatch;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_f5_sweep_ctrl.sv
// Scoreboard bench for f5_sweep_ctrl: two instances (SETTLE=1 and SETTLE=3) driving
// a behavioural f5 datapath, with monitors popping expected results on each done pulse.
module tb_f5_sweep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start1, start3, faultSb;
  logic [1:0] x1, x3;
  logic       sa1, sb1, sa3, sb3;
  logic       busy1, done1, pass1, busy3, done3, pass3;
  logic [3:0] table1, mm1, table3, mm3;

  // f5 = a'.b with a = x[1], b = x[0]; faultSb forces the expression output high.
  assign sa1 = ~x1[1] & x1[0];
  assign sb1 = faultSb ? 1'b1 : (~x1[1] & x1[0]);
  assign sa3 = ~x3[1] & x3[0];
  assign sb3 = ~x3[1] & x3[0];

  f5_sweep_ctrl #(.N_IN(2), .SETTLE(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .x(x1), .sa(sa1), .sb(sb1),
    .busy(busy1), .done(done1), .table_out(table1), .mismatch(mm1), .pass(pass1)
  );

  f5_sweep_ctrl #(.N_IN(2), .SETTLE(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .x(x3), .sa(sa3), .sb(sb3),
    .busy(busy3), .done(done3), .table_out(table3), .mismatch(mm3), .pass(pass3)
  );

  typedef struct {
    logic [3:0] tbl;
    logic [3:0] mm;
    logic       ps;
    int         doneEdge;
  } expT;

  expT q1[$];
  expT q3[$];
  int  checks = 0;
  int  passed = 0;
  int  edgeCnt = 0;

  always @(posedge clk) edgeCnt++;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edgeCnt);
  endtask

  // Monitors: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin : mon1
    expT e;
    if (done1 === 1'b1) begin
      checkOutput("done1 expected", int'(q1.size() > 0), 1);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        checkOutput("done1 edge", edgeCnt, e.doneEdge);
        checkOutput("table1", int'(table1), int'(e.tbl));
        checkOutput("mismatch1", int'(mm1), int'(e.mm));
        checkOutput("pass1", int'(pass1), int'(e.ps));
      end
    end
  end

  always @(negedge clk) begin : mon3
    expT e;
    if (done3 === 1'b1) begin
      checkOutput("done3 expected", int'(q3.size() > 0), 1);
      if (q3.size() > 0) begin
        e = q3.pop_front();
        checkOutput("done3 edge", edgeCnt, e.doneEdge);
        checkOutput("table3", int'(table3), int'(e.tbl));
        checkOutput("mismatch3", int'(mm3), int'(e.mm));
        checkOutput("pass3", int'(pass3), int'(e.ps));
      end
    end
  end

  // Pulses start1 for one cycle from a negedge; returns with edgeCnt == acceptance edge.
  task automatic applyStimulus(input logic expectDone, input logic [3:0] tbl,
                               input logic [3:0] mm, input logic ps, output int acc);
    start1 = 1'b1;
    acc = edgeCnt + 1;
    if (expectDone) q1.push_back('{tbl, mm, ps, acc + 9});
    @(negedge clk);
    start1 = 1'b0;
  endtask

  task automatic waitDone1(input int budget);
    logic seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done1 === 1'b1) seen = 1'b1;
    end
    checkOutput("done1 within budget", int'(seen), 1);
  endtask

  task automatic waitDone3(input int budget);
    logic seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done3 === 1'b1) seen = 1'b1;
    end
    checkOutput("done3 within budget", int'(seen), 1);
  endtask

  initial begin
    int acc;
    reset = 1'b1; start1 = 1'b1; start3 = 1'b1; faultSb = 1'b0;

    // Reset held three cycles with start asserted.
    repeat (3) @(negedge clk);
    checkOutput("rst busy1", int'(busy1), 0);
    checkOutput("rst done1", int'(done1), 0);
    checkOutput("rst x1", int'(x1), 0);
    checkOutput("rst table1", int'(table1), 0);
    checkOutput("rst mismatch1", int'(mm1), 0);
    checkOutput("rst pass1", int'(pass1), 0);
    checkOutput("rst busy3", int'(busy3), 0);
    checkOutput("rst x3", int'(x3), 0);
    reset = 1'b0; start1 = 1'b0; start3 = 1'b0;
    @(negedge clk);

    // Real datapath: minterm walk, busy window, result 0010 / 0000 / pass.
    applyStimulus(1'b1, 4'b0010, 4'b0000, 1'b1, acc);
    for (int d = 0; d <= 9; d++) begin
      if (d > 0) @(negedge clk);
      checkOutput($sformatf("sweep x1 d=%0d", d), int'(x1), (d < 8) ? d / 2 : 0);
      checkOutput($sformatf("sweep busy1 d=%0d", d), int'(busy1), (d < 8) ? 1 : 0);
    end
    repeat (2) @(negedge clk);

    // Fault injection on the expression output.
    faultSb = 1'b1;
    applyStimulus(1'b1, 4'b0010, 4'b1101, 1'b0, acc);
    waitDone1(20);
    faultSb = 1'b0;
    repeat (2) @(negedge clk);

    // Second start during DRIVE at idx=1 must be ignored.
    applyStimulus(1'b1, 4'b0010, 4'b0000, 1'b1, acc);
    repeat (2) @(negedge clk);
    checkOutput("ignored start x1", int'(x1), 1);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    waitDone1(20);
    repeat (12) @(negedge clk);

    // Reset while sampling idx=2 aborts without a done pulse.
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0, acc);
    repeat (5) @(negedge clk);
    checkOutput("abort pre x1", int'(x1), 2);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort x1", int'(x1), 0);
    checkOutput("abort busy1", int'(busy1), 0);
    checkOutput("abort done1", int'(done1), 0);
    checkOutput("abort table1", int'(table1), 0);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    applyStimulus(1'b1, 4'b0010, 4'b0000, 1'b1, acc);
    waitDone1(20);
    repeat (2) @(negedge clk);

    // SETTLE=3 instance with start held high: back-to-back sweeps.
    start3 = 1'b1;
    acc = edgeCnt + 1;
    q3.push_back('{4'b0010, 4'b0000, 1'b1, acc + 17});
    q3.push_back('{4'b0010, 4'b0000, 1'b1, acc + 18 + 17});
    for (int d = 0; d <= 18; d++) begin
      @(negedge clk);
      if (d < 16) checkOutput($sformatf("settle3 x3 d=%0d", d), int'(x3), d / 4);
    end
    checkOutput("reaccept table3 cleared", int'(table3), 0);
    checkOutput("reaccept busy3", int'(busy3), 1);
    start3 = 1'b0;
    waitDone3(40);
    repeat (8) @(negedge clk);

    checkOutput("q1 drained", q1.size(), 0);
    checkOutput("q3 drained", q3.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
